// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer burst scheduler: FSM encoding and
// SDRAM burst address composition.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_BUSY = 2'd1,
    ST_RD_BUSY = 2'd2
  } fb_state_e;

  // Burst start address: bank bit just above the burst index, column bits zero.
  function automatic logic [31:0] fb_compose_addr(
    input logic              bank,
    input logic [31:0]       idx,
    input int unsigned       col_w,
    input int unsigned       bidx_w
  );
    return ({31'd0, bank} << (col_w + bidx_w)) | (idx << col_w);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Burst index counter with bank bit and composed start address; used once
// for the write side (wrapping) and once for the read side (saturating).
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int COL_W      = 9,
  parameter int BIDX_W     = 7,
  parameter int DOUBLE_BUF = 1,
  parameter int WRAP       = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              i_inc,
  input  logic              i_clr,
  input  logic              i_bank_load,
  input  logic              i_bank_val,
  output logic [BIDX_W:0]   o_idx,
  output logic              o_last,
  output logic              o_bank,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [BIDX_W:0] L_LAST = {1'b0, {BIDX_W{1'b1}}};
  localparam logic [BIDX_W:0] L_NUM  = {1'b1, {BIDX_W{1'b0}}};
  localparam logic [BIDX_W:0] L_ONE  = {{BIDX_W{1'b0}}, 1'b1};

  logic [BIDX_W:0] r_idx;
  logic            r_bank;
  logic [BIDX_W:0] w_idx_nxt;
  logic            w_bank_nxt;
  logic [31:0]     w_full_addr;

  // A read-side counter parks at NUM_BURSTS so the scheduler can stall on it.
  always_comb begin
    w_idx_nxt = r_idx;
    if (i_clr) begin
      w_idx_nxt = '0;
    end else if (i_inc) begin
      if ((WRAP != 0) && (r_idx == L_LAST)) begin
        w_idx_nxt = '0;
      end else if (r_idx != L_NUM) begin
        w_idx_nxt = r_idx + L_ONE;
      end else begin
        w_idx_nxt = r_idx;
      end
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  always_comb begin
    w_bank_nxt = r_bank;
    if ((DOUBLE_BUF != 0) && i_bank_load) begin
      w_bank_nxt = i_bank_val;
    end else begin
      w_bank_nxt = r_bank;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_idx  <= '0;
      r_bank <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_bank <= w_bank_nxt;
    end
  end

  assign w_full_addr = fb_compose_addr(r_bank, {{(32-BIDX_W){1'b0}}, r_idx[BIDX_W-1:0]},
                                       COL_W, BIDX_W);

  generate
    if (ADDR_W < 32) begin : g_trim
      logic w_unused_hi;
      assign w_unused_hi = ^w_full_addr[31:ADDR_W];
    end
  endgenerate

  assign o_idx  = r_idx;
  assign o_last = (r_idx == L_LAST);
  assign o_bank = r_bank;
  assign o_addr = w_full_addr[ADDR_W-1:0];

endmodule

// File: rtl/fb_burst_scheduler.sv
// Arbitrates SDRAM write bursts (camera FIFO) and read bursts (display FIFO)
// over a single- or double-buffered frame store, one request at a time.
module fb_burst_scheduler
  import fb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int COL_W      = 9,
  parameter int BIDX_W     = 7,
  parameter int CNT_W      = 11,
  parameter int WR_THRESH  = 512,
  parameter int WR_URGENT  = 1536,
  parameter int RD_THRESH  = 512,
  parameter int DOUBLE_BUF = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              frame_start,
  input  logic [CNT_W-1:0]  wr_fifo_used,
  input  logic [CNT_W-1:0]  rd_fifo_used,
  output logic              wr_sdram_req,
  input  logic              wr_sdram_ack,
  output logic [ADDR_W-1:0] wr_sdram_add,
  output logic              rd_sdram_req,
  input  logic              rd_sdram_ack,
  output logic [ADDR_W-1:0] rd_sdram_add,
  output logic              frame_ready,
  output logic              frame_drop
);

  localparam logic [CNT_W-1:0] L_WR_THRESH = CNT_W'(WR_THRESH);
  localparam logic [CNT_W-1:0] L_WR_URGENT = CNT_W'(WR_URGENT);
  localparam logic [CNT_W-1:0] L_RD_THRESH = CNT_W'(RD_THRESH);
  localparam logic [BIDX_W:0]  L_NUM       = {1'b1, {BIDX_W{1'b0}}};

  fb_state_e         r_state;
  fb_state_e         w_state_nxt;
  logic              r_wr_req;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_wr_add;
  logic [ADDR_W-1:0] r_rd_add;
  logic              r_frame_ready;
  logic              r_frame_drop;
  logic              r_pub_bank;
  logic              r_restart_pend;

  logic              w_wr_elig, w_wr_urgent, w_rd_elig;
  logic              w_wr_grant, w_rd_grant, w_wr_done, w_rd_done;
  logic              w_restart, w_publish, w_toggle, w_drop;
  logic [BIDX_W:0]   w_rd_idx, w_unused_wr_idx;
  logic              w_wr_last, w_unused_rd_last;
  logic              w_wr_bank, w_rd_bank;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;

  assign w_wr_elig   = (wr_fifo_used >= L_WR_THRESH);
  assign w_wr_urgent = (wr_fifo_used >= L_WR_URGENT);
  assign w_rd_elig   = r_frame_ready && (rd_fifo_used <= L_RD_THRESH)
                       && (w_rd_idx < L_NUM) && !r_restart_pend;

  // Arbitration and handshake; reads win unless the camera FIFO is urgent.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_grant  = 1'b0;
    w_rd_grant  = 1'b0;
    w_wr_done   = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_elig && !w_wr_urgent) begin
          w_rd_grant  = 1'b1;
          w_state_nxt = ST_RD_BUSY;
        end else if (w_wr_elig) begin
          w_wr_grant  = 1'b1;
          w_state_nxt = ST_WR_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_BUSY: begin
        if (wr_sdram_ack) begin
          w_wr_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_BUSY;
        end
      end
      ST_RD_BUSY: begin
        if (rd_sdram_ack) begin
          w_rd_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame completion: flip banks only if that does not land on the reader.
  always_comb begin
    w_restart = r_restart_pend && ((r_state == ST_IDLE) || w_rd_done);
    w_publish = w_wr_done && w_wr_last;
    w_toggle  = 1'b0;
    w_drop    = 1'b0;
    if (w_publish && (DOUBLE_BUF != 0)) begin
      if (~w_wr_bank != w_rd_bank) begin
        w_toggle = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end else begin
      w_toggle = 1'b0;
      w_drop   = 1'b0;
    end
  end

  // Control registers and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state        <= ST_IDLE;
      r_wr_req       <= 1'b0;
      r_rd_req       <= 1'b0;
      r_wr_add       <= '0;
      r_rd_add       <= '0;
      r_frame_ready  <= 1'b0;
      r_frame_drop   <= 1'b0;
      r_pub_bank     <= 1'b0;
      r_restart_pend <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_req       <= (w_state_nxt == ST_WR_BUSY);
      r_rd_req       <= (w_state_nxt == ST_RD_BUSY);
      r_frame_drop   <= w_drop;
      r_restart_pend <= frame_start | (r_restart_pend & ~w_restart);
      if (w_wr_grant) begin
        r_wr_add <= w_wr_addr;
      end
      if (w_rd_grant) begin
        r_rd_add <= w_rd_addr;
      end
      if (w_publish) begin
        r_frame_ready <= 1'b1;
        r_pub_bank    <= w_wr_bank;
      end
    end
  end

  fb_addr_gen #(
    .ADDR_W(ADDR_W), .COL_W(COL_W), .BIDX_W(BIDX_W),
    .DOUBLE_BUF(DOUBLE_BUF), .WRAP(1)
  ) u_wr_gen (
    .CLK(CLK), .RSTn(RSTn),
    .i_inc(w_wr_done), .i_clr(1'b0),
    .i_bank_load(w_toggle), .i_bank_val(~w_wr_bank),
    .o_idx(w_unused_wr_idx), .o_last(w_wr_last),
    .o_bank(w_wr_bank), .o_addr(w_wr_addr)
  );

  fb_addr_gen #(
    .ADDR_W(ADDR_W), .COL_W(COL_W), .BIDX_W(BIDX_W),
    .DOUBLE_BUF(DOUBLE_BUF), .WRAP(0)
  ) u_rd_gen (
    .CLK(CLK), .RSTn(RSTn),
    .i_inc(w_rd_done), .i_clr(w_restart),
    .i_bank_load(w_restart), .i_bank_val(r_pub_bank),
    .o_idx(w_rd_idx), .o_last(w_unused_rd_last),
    .o_bank(w_rd_bank), .o_addr(w_rd_addr)
  );

  assign wr_sdram_req = r_wr_req;
  assign rd_sdram_req = r_rd_req;
  assign wr_sdram_add = r_wr_add;
  assign rd_sdram_add = r_rd_add;
  assign frame_ready  = r_frame_ready;
  assign frame_drop   = r_frame_drop;

endmodule

// File: tb/tb_fb_burst_scheduler.sv
// Self-checking bench: directed frame/priority/reset scenarios followed by
// randomized traffic, all compared against a behavioural frame-store model.
module tb_fb_burst_scheduler;

  localparam int ADDR_W = 24;
  localparam int CNT_W  = 11;
  localparam int NB     = 128;
  localparam int BURST  = 512;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              frame_start = 1'b0;
  logic [CNT_W-1:0]  wr_fifo_used = '0;
  logic [CNT_W-1:0]  rd_fifo_used = '0;
  logic              wr_sdram_ack = 1'b0;
  logic              rd_sdram_ack = 1'b0;
  logic              wr_sdram_req, rd_sdram_req, frame_ready, frame_drop;
  logic [ADDR_W-1:0] wr_sdram_add, rd_sdram_add;

  always #5 CLK = ~CLK;

  fb_burst_scheduler dut (
    .CLK(CLK), .RSTn(RSTn), .frame_start(frame_start),
    .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
    .wr_sdram_req(wr_sdram_req), .wr_sdram_ack(wr_sdram_ack), .wr_sdram_add(wr_sdram_add),
    .rd_sdram_req(rd_sdram_req), .rd_sdram_ack(rd_sdram_ack), .rd_sdram_add(rd_sdram_add),
    .frame_ready(frame_ready), .frame_drop(frame_drop)
  );

  int total = 0;
  int bad = 0;

  // Model of the frame store: which burst each side is on, which bank each
  // side uses, what has been published, and which request is outstanding.
  int m_wr_out, m_rd_out, m_wr_idx, m_rd_idx, m_wr_bank, m_rd_bank;
  int m_pub, m_pend, m_ready, m_drop, m_wr_add, m_rd_add;

  int auto_ack, fixed_lat, spur_pct, lat_w, lat_r, cnt_w, cnt_r;

  task automatic model_reset();
    m_wr_out = 0; m_rd_out = 0; m_wr_idx = 0; m_rd_idx = 0;
    m_wr_bank = 0; m_rd_bank = 0; m_pub = 0; m_pend = 0;
    m_ready = 0; m_drop = 0; m_wr_add = 0; m_rd_add = 0;
    cnt_w = 0; cnt_r = 0;
  endtask

  task automatic model_step();
    int wf, rf;
    bit restart, we, re;
    wf = int'(wr_fifo_used);
    rf = int'(rd_fifo_used);
    restart = 1'b0;
    m_drop = 0;
    if (m_wr_out != 0) begin
      if (wr_sdram_ack) begin
        m_wr_out = 0;
        if (m_wr_idx == NB - 1) begin
          m_wr_idx = 0;
          m_ready = 1;
          m_pub = m_wr_bank;
          if ((1 - m_wr_bank) != m_rd_bank) m_wr_bank = 1 - m_wr_bank;
          else m_drop = 1;
        end else begin
          m_wr_idx = m_wr_idx + 1;
        end
      end
    end else if (m_rd_out != 0) begin
      if (rd_sdram_ack) begin
        m_rd_out = 0;
        m_rd_idx = m_rd_idx + 1;
        restart = (m_pend != 0);
      end
    end else begin
      restart = (m_pend != 0);
      we = (wf >= 512);
      re = (m_ready != 0) && (rf <= 512) && (m_rd_idx < NB) && (m_pend == 0);
      if (re && !(wf >= 1536)) begin
        m_rd_out = 1;
        m_rd_add = m_rd_bank * NB * BURST + m_rd_idx * BURST;
      end else if (we) begin
        m_wr_out = 1;
        m_wr_add = m_wr_bank * NB * BURST + m_wr_idx * BURST;
      end
    end
    if (restart) begin
      m_rd_idx = 0;
      m_rd_bank = m_pub;
    end
    m_pend = ((m_pend != 0) && !restart) || frame_start ? 1 : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("wr_req", int'(wr_sdram_req), m_wr_out);
    chk("rd_req", int'(rd_sdram_req), m_rd_out);
    chk("frame_ready", int'(frame_ready), m_ready);
    chk("frame_drop", int'(frame_drop), m_drop);
    if (m_wr_out != 0) chk("wr_add", int'(wr_sdram_add), m_wr_add);
    if (m_rd_out != 0) chk("rd_add", int'(rd_sdram_add), m_rd_add);
  endtask

  task automatic drive_acks();
    if (auto_ack != 0) begin
      if (wr_sdram_req) begin
        cnt_w++;
        wr_sdram_ack = (cnt_w >= lat_w);
        if (wr_sdram_ack && fixed_lat == 0) lat_w = $urandom_range(1, 4);
      end else begin
        cnt_w = 0;
        wr_sdram_ack = ($urandom_range(0, 99) < spur_pct);
      end
      if (rd_sdram_req) begin
        cnt_r++;
        rd_sdram_ack = (cnt_r >= lat_r);
        if (rd_sdram_ack && fixed_lat == 0) lat_r = $urandom_range(1, 4);
      end else begin
        cnt_r = 0;
        rd_sdram_ack = ($urandom_range(0, 99) < spur_pct);
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (!RSTn) model_reset();
    else model_step();
    @(negedge CLK);
    compare();
    drive_acks();
  endtask

  initial begin
    int n, nw, nd;
    model_reset();
    auto_ack = 1; fixed_lat = 1; spur_pct = 0; lat_w = 3; lat_r = 3;
    rd_fifo_used = 11'd2047;
    wr_fifo_used = 11'd0;
    repeat (3) cycle();
    chk("rst_wr_req", int'(wr_sdram_req), 0);
    chk("rst_frame_ready", int'(frame_ready), 0);
    chk("rst_wr_add", int'(wr_sdram_add), 0);

    // One full frame at threshold fill, ack three cycles after each request.
    RSTn = 1'b1;
    wr_fifo_used = 11'd512;
    n = 0;
    while (!wr_sdram_req && n < 20) begin cycle(); n++; end
    chk("first_wr_add", int'(wr_sdram_add), 0);
    nw = 0; n = 0;
    while (!frame_ready && n < 2000) begin
      if (wr_sdram_ack) nw++;
      cycle(); n++;
    end
    chk("frame_ready_set", int'(frame_ready), 1);
    chk("bursts_per_frame", nw, 128);
    n = 0;
    while (!wr_sdram_req && n < 20) begin cycle(); n++; end
    chk("frame2_first_add", int'(wr_sdram_add), 32'h0001_0000);

    // Second frame lands in bank 1 while the reader still owns bank 0.
    nd = 0; n = 0;
    while (nw < 256 && n < 2000) begin
      if (wr_sdram_ack) nw++;
      cycle(); n++;
      if (frame_drop) nd++;
    end
    repeat (2) begin cycle(); if (frame_drop) nd++; end
    chk("drop_pulses", nd, 1);
    n = 0;
    while (!wr_sdram_req && n < 20) begin cycle(); n++; end
    chk("bank_held_add", int'(wr_sdram_add), 32'h0001_0000);

    // Read preferred over a non-urgent write.
    wr_fifo_used = 11'd0;
    n = 0;
    while ((wr_sdram_req || rd_sdram_req) && n < 20) begin cycle(); n++; end
    wr_fifo_used = 11'd600;
    rd_fifo_used = 11'd100;
    cycle();
    chk("rd_wins", int'(rd_sdram_req), 1);
    chk("wr_loses", int'(wr_sdram_req), 0);
    chk("rd_first_add", int'(rd_sdram_add), 0);

    // frame_start during a read restarts on the published bank (bank 1).
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    n = 0;
    while (rd_sdram_req && n < 20) begin cycle(); n++; end
    while (!rd_sdram_req && n < 40) begin cycle(); n++; end
    chk("restart_rd_add", int'(rd_sdram_add), 32'h0001_0000);

    // Urgent write beats an eligible read.
    wr_fifo_used = 11'd0;
    rd_fifo_used = 11'd2047;
    n = 0;
    while ((wr_sdram_req || rd_sdram_req) && n < 20) begin cycle(); n++; end
    wr_fifo_used = 11'd1600;
    rd_fifo_used = 11'd100;
    cycle();
    chk("urgent_wr_wins", int'(wr_sdram_req), 1);
    chk("rd_defers", int'(rd_sdram_req), 0);

    // Reset in the middle of the write burst.
    #1;
    RSTn = 1'b0;
    #1;
    chk("async_rst_req", int'(wr_sdram_req), 0);
    model_reset();
    wr_sdram_ack = 1'b0;
    rd_sdram_ack = 1'b0;
    repeat (2) cycle();
    chk("rst_ready_clear", int'(frame_ready), 0);
    RSTn = 1'b1;

    // Spurious write ack in IDLE must not move the index or raise a request.
    wr_fifo_used = 11'd0;
    rd_fifo_used = 11'd2047;
    auto_ack = 0;
    wr_sdram_ack = 1'b1;
    cycle();
    wr_sdram_ack = 1'b0;
    chk("spurious_no_req", int'(wr_sdram_req), 0);
    auto_ack = 1;
    wr_fifo_used = 11'd600;
    n = 0;
    while (!wr_sdram_req && n < 20) begin cycle(); n++; end
    chk("post_rst_wr_add", int'(wr_sdram_add), 0);

    // Randomized traffic with random latencies, spurious acks and vsyncs.
    fixed_lat = 0;
    spur_pct = 10;
    repeat (30000) begin
      case ($urandom_range(0, 5))
        0: wr_fifo_used = 11'd511;
        1: wr_fifo_used = 11'd512;
        2: wr_fifo_used = 11'd1535;
        3: wr_fifo_used = 11'd1536;
        default: wr_fifo_used = CNT_W'($urandom_range(0, 2047));
      endcase
      case ($urandom_range(0, 3))
        0: rd_fifo_used = 11'd512;
        1: rd_fifo_used = 11'd513;
        default: rd_fifo_used = CNT_W'($urandom_range(0, 1023));
      endcase
      frame_start = ($urandom_range(0, 299) == 0);
      cycle();
    end
    frame_start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
